// File: rtl/contador_crescente_temporizador.sv
// contador_crescente_temporizador: prescaled up-counting round/move timer with IDLE/RUN/PAUSE/DONE control.
// Define CONTADOR_AUTO_RELOAD_EN for periodic (auto-reload) operation; default build is one-shot.
module contador_crescente_temporizador #(
  parameter int WIDTH    = 6,
  parameter int PRESCALE = 1000
) (
  input  logic             clock,
  input  logic             clr,
  input  logic             iniciar,
  input  logic             pausar,
  input  logic             zerar,
  input  logic [WIDTH-1:0] limite,
  output logic [WIDTH-1:0] Q,
  output logic             rco,
  output logic             ativo,
  output logic             fim
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
`ifdef CONTADOR_AUTO_RELOAD_EN
  localparam bit RELOAD = 1'b1;
`else
  localparam bit RELOAD = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [WIDTH-1:0] q_q, q_d, lim_q, lim_d;
  logic rco_q, rco_d, ativo_q, fim_q;
  logic step, tick, last, start;
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    q_d     = q_q;
    lim_d   = lim_q;
    rco_d   = 1'b0;
    start   = iniciar && (state_q == IDLE || state_q == DONE);
    // iniciar outranks pausar, and a resume edge already counts as a run edge
    step    = (state_q == RUN && (iniciar || !pausar)) || (state_q == PAUSE && iniciar);
    tick    = presc_q == PW'(PRESCALE - 1);
    last    = (RELOAD && lim_q == '0) || ({1'b0, q_q} + (WIDTH+1)'(1)) == {1'b0, lim_q};
    if (zerar) begin
      state_d = IDLE;
      q_d     = '0;
      presc_d = '0;
    end else if (start) begin
      lim_d   = limite;
      q_d     = '0;
      presc_d = '0;
      state_d = (!RELOAD && limite == '0) ? DONE : RUN;
      rco_d   = !RELOAD && limite == '0;
    end else if (step) begin
      state_d = RUN;
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick && last) begin
        rco_d   = 1'b1;
        q_d     = RELOAD ? '0 : lim_q;
        state_d = RELOAD ? RUN : DONE;
      end else if (tick) begin
        q_d = q_q + WIDTH'(1);
      end
    end else if (state_q == RUN && pausar) begin
      state_d = PAUSE;
    end
  end
  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      presc_q <= '0;
      q_q     <= '0;
      lim_q   <= '0;
      rco_q   <= 1'b0;
      ativo_q <= 1'b0;
      fim_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      q_q     <= q_d;
      lim_q   <= lim_d;
      rco_q   <= rco_d;
      ativo_q <= state_d == RUN;
      fim_q   <= state_d == DONE;
    end
  end
  assign Q     = q_q;
  assign rco   = rco_q;
  assign ativo = ativo_q;
  assign fim   = fim_q;
endmodule
